ram_arbiter: RTL

- Shares the single-port data RAM between two requesters: master 0 (CPU load/store unit) and master 1 (JPEG block DMA).
- Arbitrates per cycle with round-robin fairness.
- Drives the RAM port. Registers read data and returns it one cycle later with a valid strobe.
- Sits between the core/DMA and the RAM in the SoC top.

---
 rtl/ram_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/ram_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types, region map and address decode for the RAM arbiter
package ram_arb_pkg;

  localparam int DATA_W    = 32;
  localparam int CONST_TOP = 1207;
  localparam int BLOCK_TOP = 1536;
  localparam int ROW_BASE  = 2000;
  localparam int ROW_TOP   = 3024;

  typedef logic [0:0] master_idx_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

  function automatic logic unmapped(input logic [DATA_W-1:0] a);
    return (a > DATA_W'(BLOCK_TOP) && a < DATA_W'(ROW_BASE)) || a > DATA_W'(ROW_TOP);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant; a tie goes to the master not granted last
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  master_idx_t last_gnt;

  // single requester wins outright, a tie goes to whoever was not granted last
  always_comb begin
    gnt = (req == 2'b11) ? ((last_gnt == 1'b1) ? 2'b01 : 2'b10) : req;
  end

  // remember the last winner; reset to master 1 so master 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_gnt <= 1'b1;
    else if (|gnt) last_gnt <= gnt[1];
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port data RAM between the CPU LSU (m0) and JPEG DMA (m1)
// Optional unmapped-address trapping: define RAM_ARB_ADDR_CHECK_EN
module ram_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,
  output logic             m0_err,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             m1_err,
  output logic [WIDTH-1:0] ram_address,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_enw,
  input  logic [WIDTH-1:0] ram_rdata
);
  import ram_arb_pkg::*;

  logic [1:0]       gnt;
  ram_req_t         req0, req1, cur;
  logic             busy, bad, rd;
  logic [WIDTH-1:0] rd_val;
  logic             pend_rd, pend_err;
  master_idx_t      pend_sel;
  logic [WIDTH-1:0] rdata0, rdata1;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({m1_req, m0_req}),
    .gnt   (gnt)
  );

  assign req0 = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
  assign req1 = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};

  // route the granted master onto the RAM port; idle drives zeros
  always_comb begin
    busy = |gnt;
    cur = gnt[1] ? req1 : req0;
`ifdef RAM_ARB_ADDR_CHECK_EN
    bad = busy && unmapped(cur.addr);
`else
    bad = 1'b0;
`endif
    rd = busy && !cur.we;
    rd_val = bad ? '0 : ram_rdata;
    ram_address = busy ? cur.addr : '0;
    ram_wdata = busy ? cur.wdata : '0;
    ram_enw = busy && cur.we && !bad;
  end

  // one-cycle response bookkeeping: who was served, read or not, trapped or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rd <= 1'b0;
      pend_err <= 1'b0;
      pend_sel <= 1'b0;
    end else begin
      pend_rd <= rd;
      pend_err <= bad;
      if (busy) pend_sel <= gnt[1];
    end
  end

  // capture read data for its owner; each register holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (rd) begin
      if (gnt[0]) rdata0 <= rd_val;
      else rdata1 <= rd_val;
    end
  end

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];
  assign m0_rvalid = pend_rd && (pend_sel == 1'b0);
  assign m1_rvalid = pend_rd && (pend_sel == 1'b1);
  assign m0_err = pend_err && (pend_sel == 1'b0);
  assign m1_err = pend_err && (pend_sel == 1'b1);
  assign m0_rdata = rdata0;
  assign m1_rdata = rdata1;

endmodule
